// File: rtl/synapse_row_writer.sv
// Assembles a serial stream of connection words into one NUM_AXONS-bit row and writes it to the connection store.
// Optional macro SYNROW_POPCOUNT_EN: conn_count reports the number of set bits in the written row (else tied to 0).
module synapse_row_writer #(
    parameter int unsigned NUM_AXONS   = 256,
    parameter int unsigned NUM_NEURONS = 256,
    parameter int unsigned WORD_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [$clog2(NUM_NEURONS)-1:0] cfg_neuron,
    input  logic                           cfg_abort,
    input  logic                           cfg_valid,
    input  logic [WORD_W-1:0]              cfg_data,
    output logic                           cfg_ready,
    output logic                           busy,
    output logic                           wr_en,
    output logic [$clog2(NUM_NEURONS)-1:0] wr_addr,
    output logic [NUM_AXONS-1:0]           wr_data,
    output logic                           done,
    output logic [$clog2(NUM_AXONS):0]     conn_count
);

    localparam int unsigned AW        = $clog2(NUM_NEURONS);
    localparam int unsigned NUM_WORDS = NUM_AXONS / WORD_W;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    generate
        if ((NUM_AXONS % WORD_W) != 0) begin : g_bad_word_w
            $error("synapse_row_writer: NUM_AXONS must be a multiple of WORD_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    state_t               state;
    logic [AW-1:0]        neuron_q;
    logic [NUM_AXONS-1:0] row;
    logic [NUM_AXONS-1:0] row_next;
    logic [CNT_W-1:0]     word_cnt;
    logic                 xfer;
    logic                 last_word;

    assign xfer      = cfg_valid & cfg_ready;
    assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

    // Current row with the incoming word merged into its slot
    always_comb begin
        row_next = row;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            if (word_cnt == CNT_W'(k)) begin
                row_next[k*WORD_W +: WORD_W] = cfg_data;
            end
        end
    end

    // Control FSM with registered handshake and write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            neuron_q  <= '0;
            row       <= '0;
            word_cnt  <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        neuron_q  <= cfg_neuron;
                        row       <= '0;
                        word_cnt  <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Abort wins over a same-cycle transfer; that word is dropped
                    if (cfg_abort) begin
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (xfer) begin
                        row <= row_next;
                        if (last_word) begin
                            cfg_ready <= 1'b0;
                            wr_en     <= 1'b1;
                            done      <= 1'b1;
                            wr_addr   <= neuron_q;
                            wr_data   <= row_next;
                            state     <= WRITE;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SYNROW_POPCOUNT_EN
    localparam int unsigned POP_W  = $clog2(NUM_AXONS) + 1;
    localparam int unsigned WPOP_W = $clog2(WORD_W) + 1;

    function automatic logic [WPOP_W-1:0] word_pop(input logic [WORD_W-1:0] w);
        logic [WPOP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            c = c + WPOP_W'(w[i]);
        end
        return c;
    endfunction

    logic [POP_W-1:0] pop_acc;
    logic [POP_W-1:0] pop_next;

    assign pop_next = pop_acc + POP_W'(word_pop(cfg_data));

    // Running set-bit count; published only when the row is written
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_acc    <= '0;
            conn_count <= '0;
        end else if (state == IDLE && cfg_start) begin
            pop_acc <= '0;
        end else if (state == LOAD && !cfg_abort && xfer) begin
            pop_acc <= pop_next;
            if (last_word) begin
                conn_count <= pop_next;
            end
        end
    end
`else
    assign conn_count = '0;
`endif

endmodule

// File: tb/tb_synapse_row_writer.sv
// Directed self-checking bench for synapse_row_writer at default parameters.
// Works with or without SYNROW_POPCOUNT_EN; expected conn_count follows the macro.
module tb_synapse_row_writer;

`ifdef SYNROW_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_start = 1'b0;
    logic [7:0]   cfg_neuron = '0;
    logic         cfg_abort = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [7:0]   cfg_data = '0;
    logic         cfg_ready;
    logic         busy;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [255:0] wr_data;
    logic         done;
    logic [8:0]   conn_count;

    int n_cmp = 0;
    int n_err = 0;

    int           n_wr = 0;
    int           n_done = 0;
    int           n_skew = 0;
    logic [255:0] cap_data = '0;
    logic [7:0]   cap_addr = '0;
    logic [8:0]   cap_count = '0;

    synapse_row_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_neuron (cfg_neuron),
        .cfg_abort  (cfg_abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done),
        .conn_count (conn_count)
    );

    always #5 clk = ~clk;

    // Records every write-port strobe seen mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            cap_data  = wr_data;
            cap_addr  = wr_addr;
            cap_count = conn_count;
        end
        if (done) n_done++;
        if (done !== wr_en) n_skew++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input logic [7:0] n);
        cfg_start  = 1'b1;
        cfg_neuron = n;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (wr_addr !== 8'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_cmp++; if (wr_data !== 256'd0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_cmp++; if (conn_count !== 9'd0) begin n_err++; $display("FAIL reset_conn_count: got %0d want 0", conn_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_ones();
        int w0 = n_wr;
        int d0 = n_done;
        logic [8:0] exp_cnt = POP_EN ? 9'd256 : 9'd0;
        start_row(8'd5);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL ones_ready_after_start: got %b want 1", cfg_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ones_busy_after_start: got %b want 1", busy); end
        for (int k = 0; k < 32; k++) send_word(8'hFF);
        // cycle 34 counted from the start cycle: the write cycle
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL ones_wr_en: got %b want 1", wr_en); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ones_done: got %b want 1", done); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL ones_ready_in_write: got %b want 0", cfg_ready); end
        n_cmp++; if (wr_addr !== 8'd5) begin n_err++; $display("FAIL ones_wr_addr: got %0d want 5", wr_addr); end
        n_cmp++; if (wr_data !== {256{1'b1}}) begin n_err++; $display("FAIL ones_wr_data: got %h want all ones", wr_data); end
        n_cmp++; if (conn_count !== exp_cnt) begin n_err++; $display("FAIL ones_conn_count: got %0d want %0d", conn_count, exp_cnt); end
        // start held through WRITE must only be taken once back in IDLE
        cfg_start  = 1'b1;
        cfg_neuron = 8'd6;
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ones_wr_en_drop: got %b want 0", wr_en); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL ones_start_in_write: got %b want 0", cfg_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ones_idle_busy: got %b want 0", busy); end
        n_cmp++; if (wr_addr !== 8'd5) begin n_err++; $display("FAIL ones_addr_held: got %0d want 5", wr_addr); end
        n_cmp++; if (wr_data !== {256{1'b1}}) begin n_err++; $display("FAIL ones_data_held: got %h want all ones", wr_data); end
        tick();
        cfg_start = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL b2b_start_accepted: got %b want 1", cfg_ready); end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_cmp++; if ((n_wr - w0) !== 1) begin n_err++; $display("FAIL ones_write_count: got %0d want 1", n_wr - w0); end
        n_cmp++; if ((n_done - d0) !== 1) begin n_err++; $display("FAIL ones_done_count: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_stalled_sparse();
        int w0 = n_wr;
        logic [255:0] exp = '0;
        logic [8:0] exp_cnt = POP_EN ? 9'd32 : 9'd0;
        for (int k = 0; k < 32; k++) exp[k*8 +: 8] = 8'h01;
        start_row(8'd200);
        for (int k = 0; k < 32; k++) begin
            send_word(8'h01);
            tick();
        end
        repeat (2) tick();
        n_cmp++; if ((n_wr - w0) !== 1) begin n_err++; $display("FAIL sparse_write_count: got %0d want 1", n_wr - w0); end
        n_cmp++; if (cap_addr !== 8'd200) begin n_err++; $display("FAIL sparse_addr: got %0d want 200", cap_addr); end
        n_cmp++; if (cap_data !== exp) begin n_err++; $display("FAIL sparse_data: got %h want %h", cap_data, exp); end
        n_cmp++; if (cap_count !== exp_cnt) begin n_err++; $display("FAIL sparse_count: got %0d want %0d", cap_count, exp_cnt); end
        n_cmp++; if (wr_data !== exp) begin n_err++; $display("FAIL sparse_data_held: got %h want %h", wr_data, exp); end
    endtask

    task automatic test_word_order();
        int w0 = n_wr;
        logic [255:0] exp = '0;
        logic [8:0] exp_cnt = POP_EN ? 9'd80 : 9'd0;
        for (int k = 0; k < 32; k++) exp[k*8 +: 8] = 8'(k);
        start_row(8'd17);
        for (int k = 0; k < 32; k++) send_word(8'(k));
        tick();
        n_cmp++; if ((n_wr - w0) !== 1) begin n_err++; $display("FAIL order_write_count: got %0d want 1", n_wr - w0); end
        n_cmp++; if (cap_addr !== 8'd17) begin n_err++; $display("FAIL order_addr: got %0d want 17", cap_addr); end
        n_cmp++; if (cap_data !== exp) begin n_err++; $display("FAIL order_data: got %h want %h", cap_data, exp); end
        n_cmp++; if (cap_count !== exp_cnt) begin n_err++; $display("FAIL order_count: got %0d want %0d", cap_count, exp_cnt); end
    endtask

    task automatic test_abort();
        int w0 = n_wr;
        int d0 = n_done;
        logic [255:0] exp = '0;
        logic [8:0] exp_cnt = POP_EN ? 9'd88 : 9'd0;
        start_row(8'd9);
        for (int k = 0; k < 10; k++) send_word(8'hAA);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h55;
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL abort_wr_en: got %b want 0", wr_en); end
        repeat (2) tick();
        n_cmp++; if ((n_wr - w0) !== 0) begin n_err++; $display("FAIL abort_no_write: got %0d want 0", n_wr - w0); end
        n_cmp++; if ((n_done - d0) !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", n_done - d0); end
        for (int k = 10; k < 32; k++) exp[k*8 +: 8] = 8'h3C;
        start_row(8'd7);
        for (int k = 0; k < 32; k++) send_word((k < 10) ? 8'h00 : 8'h3C);
        tick();
        n_cmp++; if ((n_wr - w0) !== 1) begin n_err++; $display("FAIL post_abort_write_count: got %0d want 1", n_wr - w0); end
        n_cmp++; if (cap_addr !== 8'd7) begin n_err++; $display("FAIL post_abort_addr: got %0d want 7", cap_addr); end
        n_cmp++; if (cap_data !== exp) begin n_err++; $display("FAIL post_abort_data: got %h want %h", cap_data, exp); end
        n_cmp++; if (cap_count !== exp_cnt) begin n_err++; $display("FAIL post_abort_count: got %0d want %0d", cap_count, exp_cnt); end
    endtask

    task automatic test_rst_mid_load();
        int w0 = n_wr;
        start_row(8'd3);
        for (int k = 0; k < 20; k++) send_word(8'hF0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_cmp++; if (wr_addr !== 8'd0) begin n_err++; $display("FAIL rst_mid_wr_addr: got %0d want 0", wr_addr); end
        n_cmp++; if (wr_data !== 256'd0) begin n_err++; $display("FAIL rst_mid_wr_data: got %h want 0", wr_data); end
        n_cmp++; if (conn_count !== 9'd0) begin n_err++; $display("FAIL rst_mid_conn_count: got %0d want 0", conn_count); end
        repeat (3) tick();
        n_cmp++; if ((n_wr - w0) !== 0) begin n_err++; $display("FAIL rst_mid_no_write: got %0d want 0", n_wr - w0); end
    endtask

    task automatic test_start_ignored();
        int w0 = n_wr;
        logic [8:0] exp_cnt = POP_EN ? 9'd128 : 9'd0;
        start_row(8'd11);
        for (int k = 0; k < 5; k++) send_word(8'hC3);
        cfg_start  = 1'b1;
        cfg_neuron = 8'd250;
        tick();
        cfg_start  = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL restart_ready: got %b want 1", cfg_ready); end
        for (int k = 5; k < 32; k++) send_word(8'hC3);
        tick();
        n_cmp++; if ((n_wr - w0) !== 1) begin n_err++; $display("FAIL restart_write_count: got %0d want 1", n_wr - w0); end
        n_cmp++; if (cap_addr !== 8'd11) begin n_err++; $display("FAIL restart_addr: got %0d want 11", cap_addr); end
        n_cmp++; if (cap_data !== {32{8'hC3}}) begin n_err++; $display("FAIL restart_data: got %h want all C3", cap_data); end
        n_cmp++; if (cap_count !== exp_cnt) begin n_err++; $display("FAIL restart_count: got %0d want %0d", cap_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_stalled_sparse();
        test_word_order();
        test_abort();
        test_rst_mid_load();
        test_start_ignored();
        n_cmp++; if (n_skew !== 0) begin n_err++; $display("FAIL done_wr_en_coincident: got %0d skewed cycles want 0", n_skew); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/synapse_row_writer.md
# synapse_row_writer

Programming-side counterpart of the synaptic connection lookup. Accepts a serial stream of connection words for one neuron, assembles them into a full NUM_AXONS-bit connection row, and issues a single-cycle write into the core's connection store at that neuron's address. Sits between the configuration/packet interface and the connection memory that the per-axon lookup reads during evaluation.

## Interface
- NUM_AXONS, 256, axons per core; width of one connection row
- NUM_NEURONS, 256, neurons per core; number of rows in the connection store
- WORD_W, 8, width of one configuration word; NUM_AXONS must be a multiple of WORD_W (elaboration error otherwise)

- clk  in  1  core clock, all logic rising-edge
- rst  in  1  reset rst, synchronous, active-high
- cfg_start  in  1  begin programming a row; sampled only in IDLE
- cfg_neuron  in  $clog2(NUM_NEURONS)  target row, latched with cfg_start
- cfg_abort  in  1  drop the current row without writing
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  WORD_W  connection bits, bit i = axon (word_index*WORD_W + i)
- cfg_ready  out  1  block accepts a word this cycle
- busy  out  1  high in LOAD and WRITE
- wr_en  out  1  one-cycle write strobe to the connection store
- wr_addr  out  $clog2(NUM_NEURONS)  row address, valid with wr_en
- wr_data  out  NUM_AXONS  assembled row, valid with wr_en
- done  out  1  one-cycle pulse, coincident with wr_en
- conn_count  out  $clog2(NUM_AXONS)+1  number of set bits in the written row

## Operation
- States: IDLE, LOAD, WRITE.
- IDLE: cfg_ready=0, busy=0. cfg_start=1 → latch cfg_neuron, clear row register, word counter and count → LOAD.
- LOAD: cfg_ready=1. Transfer when cfg_valid & cfg_ready; word k is written to row bits [k*WORD_W +: WORD_W], counter increments. Transfer of word NUM_AXONS/WORD_W-1 → WRITE. cfg_valid low simply stalls; no timeout.
- WRITE: cfg_ready=0; wr_en=1, done=1, wr_addr=latched neuron, wr_data=row for exactly one cycle → IDLE.
- cfg_abort in LOAD (takes priority over a same-cycle transfer) → IDLE, no wr_en, no done; the word in that cycle is not consumed. cfg_abort ignored in IDLE and WRITE.
- cfg_start outside IDLE ignored (no re-latch of cfg_neuron).
- Word counter width $clog2(NUM_AXONS/WORD_W) (minimum 1); compares against terminal value, never wraps into the next row.

## Timing
- Reset values: state IDLE, cfg_ready=0, busy=0, wr_en=0, done=0, wr_addr=0, wr_data=0, conn_count=0. rst mid-LOAD discards the partial row; no write issued.
- cfg_start sampled at edge t → cfg_ready high in cycle t+1.
- Last word accepted at edge n → wr_en/done high in cycle n+1, cfg_ready low in that cycle, IDLE from n+2; a cfg_start at edge n+2 is accepted.
- Minimum row time: 1 + NUM_AXONS/WORD_W + 1 cycles (34 at defaults).
- wr_addr, wr_data, conn_count hold their last values after WRITE until the next write.
- All outputs registered; no combinational path from cfg_* to outputs except none (cfg_ready depends on state only).

## Configuration
- SYNROW_POPCOUNT_EN defined: conn_count accumulates popcount of each accepted word, cleared on cfg_start, final value valid with done and held afterwards.
- Not defined: no popcount logic; conn_count tied to 0. All other behaviour identical.

## Test plan
- Defaults, cfg_neuron=5, 32 words of 0xFF back-to-back → one wr_en, wr_addr=5, wr_data all ones, conn_count=256 (macro on) / 0 (off), done at cycle 34 after start.
- cfg_neuron=200, 32 words of 0x01 with cfg_valid low every other cycle → wr_data bits 0,8,…,248 set only, conn_count=32, exactly one wr_en.
- Word k = k (0x00..0x1F) → wr_data[k*8 +: 8]==k for all k; confirms word ordering and LSB = lowest axon.
- cfg_abort with cfg_valid high after 10 words → no wr_en, no done, IDLE next cycle; following full row to neuron 7 writes correct data with no residue.
- rst asserted after 20 words → all outputs at reset values next cycle, no write; cfg_start during LOAD with different cfg_neuron → ignored, write goes to original address.
